// File: rtl/npu_tile_scheduler.sv
// Purpose: walks a rectangular tile range (j inner, i outer), one tp_start per tile.
// Latency: accept->tp_start 2 cycles; per tile 1 issue + N wait + 1 step; last tp_done->done 2 cycles.
// Backpressure: cmd_ready low while a command runs; tile issue stalls while spi_busy is high.
module npu_tile_scheduler #(
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [IDX_W-1:0] cmd_i_start,
    input  logic [IDX_W-1:0] cmd_i_end,
    input  logic [IDX_W-1:0] cmd_j_start,
    input  logic [IDX_W-1:0] cmd_j_end,
    input  logic             abort,
    input  logic             spi_busy,
    output logic             tp_start,
    output logic [IDX_W-1:0] tp_tile_i,
    output logic [IDX_W-1:0] tp_tile_j,
    output logic [2:0]       tp_op_code,
    input  logic             tp_done,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] tiles_done,
    output logic             err_range,
    output logic             err_timeout
);

    localparam int              WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] j_first;
    logic [IDX_W-1:0] i_last;
    logic [IDX_W-1:0] j_last;
    logic [WD_W-1:0]  wd;
    logic             range_ok;
    logic             accept;
    logic             last_tile;

    // tp_tile_i/j double as the current raster position
    assign range_ok  = (cmd_i_start <= cmd_i_end) && (cmd_j_start <= cmd_j_end);
    assign accept    = (state == S_IDLE) && cmd_valid && cmd_ready;
    assign last_tile = (tp_tile_i == i_last) && (tp_tile_j == j_last);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort outranks everything outside IDLE, tp_done outranks watchdog expiry
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept && range_ok) begin
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    next_state = S_IDLE;
                end else if (!spi_busy) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    next_state = S_IDLE;
                end else if (tp_done && !tp_start) begin
                    // tp_start is high only in the first WAIT cycle, so done is ignored there
                    next_state = S_NEXT;
                end else if (wd == WD_LAST) begin
                    next_state = S_FINISH;
                end
            end
            S_NEXT: begin
                if (abort) begin
                    next_state = S_IDLE;
                end else if (last_tile) begin
                    next_state = S_FINISH;
                end else begin
                    next_state = S_ISSUE;
                end
            end
            S_FINISH: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Registered outputs, command latch, raster stepping, watchdog and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready   <= 1'b0;
            busy        <= 1'b0;
            tp_start    <= 1'b0;
            done        <= 1'b0;
            tiles_done  <= '0;
            err_range   <= 1'b0;
            err_timeout <= 1'b0;
            tp_tile_i   <= '0;
            tp_tile_j   <= '0;
            tp_op_code  <= '0;
            j_first     <= '0;
            i_last      <= '0;
            j_last      <= '0;
            wd          <= '0;
        end else begin
            cmd_ready <= (next_state == S_IDLE);
            busy      <= (next_state == S_ISSUE) || (next_state == S_WAIT) || (next_state == S_NEXT);
            tp_start  <= (state == S_ISSUE) && (next_state == S_WAIT);
            done      <= (next_state == S_FINISH) || (accept && !range_ok);

            // Watchdog only runs in WAIT; any other state holds it at zero
            if (state == S_WAIT) begin
                wd <= wd + WD_W'(1);
            end else begin
                wd <= '0;
            end

            if (accept) begin
                tp_op_code  <= cmd_op;
                tp_tile_i   <= cmd_i_start;
                tp_tile_j   <= cmd_j_start;
                j_first     <= cmd_j_start;
                i_last      <= cmd_i_end;
                j_last      <= cmd_j_end;
                tiles_done  <= '0;
                err_timeout <= 1'b0;
                err_range   <= !range_ok;
            end

            if ((state == S_WAIT) && (next_state == S_FINISH)) begin
                err_timeout <= 1'b1;
            end

            if ((state == S_NEXT) && !abort) begin
                tiles_done <= tiles_done + CNT_W'(1);
                if (!last_tile) begin
                    if (tp_tile_j == j_last) begin
                        tp_tile_j <= j_first;
                        tp_tile_i <= tp_tile_i + IDX_W'(1);
                    end else begin
                        tp_tile_j <= tp_tile_j + IDX_W'(1);
                    end
                end
            end
        end
    end

endmodule
